// File: rtl/subtractor_8bit_serial.sv
// ---------------------------------------------------------------------------
// subtractor_8bit_serial
//
// Bit-serial 8-bit subtractor: Diff = A - B - Bin, one bit per clock, LSB
// first. Uses the same one-bit full-adder cell as the ripple-carry adder in
// complement form: A + ~B + ~Bin, with borrow = ~carry. The start/done
// handshake gives an 8-cycle latency. The result flags are registered.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous, active-high reset
//   start  in   request; taken on an edge where busy=0 (IDLE or DONE)
//   A      in   [7:0] minuend
//   B      in   [7:0] subtrahend
//   Bin    in   borrow-in
//   busy   out  operation in progress (RUN)
//   done   out  one-cycle pulse; Diff/Bout/Ovf were just updated
//   Diff   out  [7:0] (A - B - Bin) mod 256
//   Bout   out  unsigned borrow-out (A < B + Bin)
//   Ovf    out  signed overflow of the two's-complement difference
// ---------------------------------------------------------------------------
module subtractor_8bit_serial (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Bin,
    output logic       busy,
    output logic       done,
    output logic [7:0] Diff,
    output logic       Bout,
    output logic       Ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q,   cnt_d;
    logic [7:0] a_q,     a_d;
    logic [7:0] b_q,     b_d;
    logic       brw_q,   brw_d;     // running borrow into the current bit
    logic [7:0] pd_q,    pd_d;      // partial difference, filled from MSB side
    logic [7:0] diff_q,  diff_d;
    logic       bout_q,  bout_d;
    logic       ovf_q,   ovf_d;

    // One-bit subtract cell. This is the complemented full adder
    // a + ~b + ~borrow. Its sum reduces to a^b^borrow, and its inverted
    // carry is the borrow expression below.
    logic d_bit;
    logic brw_next;

    always_comb begin
        d_bit    = a_q[0] ^ b_q[0] ^ brw_q;
        brw_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        brw_d   = brw_q;
        pd_d    = pd_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                // DONE accepts a new start directly, so back-to-back
                // operations skip the IDLE cycle.
                if (start) begin
                    state_d = RUN;
                    a_d     = A;
                    b_d     = B;
                    brw_d   = Bin;
                    cnt_d   = 3'd0;
                    pd_d    = 8'h00;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                brw_d = brw_next;
                pd_d  = {d_bit, pd_q[7:1]};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = DONE;
                    diff_d  = {d_bit, pd_q[7:1]};
                    bout_d  = brw_next;
                    // Signed overflow is the borrow into the sign bit XOR
                    // the borrow out of it.
                    ovf_d   = brw_q ^ brw_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            brw_q   <= 1'b0;
            pd_q    <= 8'h00;
            diff_q  <= 8'h00;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            brw_q   <= brw_d;
            pd_q    <= pd_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign Diff = diff_q;
    assign Bout = bout_q;
    assign Ovf  = ovf_q;

endmodule
